sr_gain_telemetry_framer: RTL and testbench

- Hardware counterpart of the bench-side continuous-gain export.
- Sits downstream of phi_n_neural_processor: consumes per-harmonic coherence, thalamic gains, beta factor, dynamic gain, SIE mask and beta_quiet.
- On every DECIM-th rising edge of the 4 kHz enable, snapshots those signals into a fixed 43-byte frame.
- Streams the frame out over a byte-wide valid/ready interface, normally feeding the board UART/telemetry link.

---
 rtl/sr_telemetry_pkg.sv | 14 +
 rtl/sr_frame_byte_mux.sv | 17 +
 rtl/sr_gain_telemetry_framer.sv | 103 ++++++++++
 tb/tb_sr_gain_telemetry_framer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sr_telemetry_pkg.sv
// sr_telemetry_pkg: shared frame layout constants and FSM state type for the gain telemetry framer.
package sr_telemetry_pkg;
  localparam logic [7:0] SYNC0 = 8'hA5;
  localparam logic [7:0] SYNC1 = 8'h5A;
  localparam int FRAME_LEN = 43;
  localparam int FIELD_BASE = 6;
  localparam int NUM_FIELDS = 12;
  localparam int FIELD_BYTES = 3;
  localparam int FIELD_W = FIELD_BYTES * 8;
  // The snapshot holds frame bytes 2..41 MSB-first; sync bytes and checksum are not stored.
  localparam int SNAP_BYTES = FRAME_LEN - 3;
  localparam int SNAP_W = SNAP_BYTES * 8;
  typedef enum logic {IDLE, SEND} state_e;
endpackage

// File: rtl/sr_frame_byte_mux.sv
// sr_frame_byte_mux: selects the frame byte at a given index from the captured snapshot.
module sr_frame_byte_mux
  import sr_telemetry_pkg::*;
(
  input  logic [SNAP_W-1:0] snap,
  input  logic [5:0]        idx,
  input  logic [7:0]        csum,
  output logic [7:0]        data
);
  logic [8:0] sel;
  always_comb begin
    sel = 9'(6'(FRAME_LEN - 2) - idx) << 3;
    data = idx == 6'd0 ? SYNC0 :
           idx == 6'd1 ? SYNC1 :
           idx == 6'(FRAME_LEN - 1) ? csum : snap[sel +: 8];
  end
endmodule

// File: rtl/sr_gain_telemetry_framer.sv
// sr_gain_telemetry_framer: decimated snapshot of processor gains streamed as a 43-byte checksummed frame.
module sr_gain_telemetry_framer
  import sr_telemetry_pkg::*;
#(
  parameter int WIDTH = 18,
  parameter int FRAC = 14,
  parameter int NUM_HARMONICS = 5,
  parameter int DECIM = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clk_en,
  input  logic [2:0]                     phase_tag,
  input  logic [NUM_HARMONICS*WIDTH-1:0] coherence_packed,
  input  logic [NUM_HARMONICS*WIDTH-1:0] gain_packed,
  input  logic [WIDTH-1:0]               beta_factor,
  input  logic [WIDTH-1:0]               dynamic_gain,
  input  logic [NUM_HARMONICS-1:0]       sie_mask,
  input  logic                           beta_quiet,
  output logic [7:0]                     m_data,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [15:0]                    frame_seq,
  output logic [15:0]                    drop_count,
  output logic                           busy
);
  if (FRAC >= WIDTH || WIDTH > FIELD_W || DECIM < 1 || DECIM > 255 || NUM_HARMONICS != 5) begin : g_param_check
    $error("sr_gain_telemetry_framer: unsupported parameter set");
  end

  state_e state_q, state_d;
  logic prev_en_q;
  logic [7:0] dec_q, dec_d, csum_q, csum_d, byte_w;
  logic [5:0] idx_q, idx_d;
  logic [15:0] seq_q, seq_d, drop_q, drop_d, seq_inc;
  logic [SNAP_W-1:0] snap_q, snap_d, snap_in;
  logic [WIDTH-1:0] raw [NUM_FIELDS];
  logic [NUM_FIELDS*FIELD_W-1:0] fields;
  logic rise, cap, hs, start;

  always_comb begin
    seq_inc = seq_q + 16'd1;
    raw[0] = beta_factor;
    raw[NUM_FIELDS-1] = dynamic_gain;
    for (int h = 0; h < NUM_HARMONICS; h++) begin
      raw[1+h] = coherence_packed[h*WIDTH +: WIDTH];
      raw[1+NUM_HARMONICS+h] = gain_packed[h*WIDTH +: WIDTH];
    end
    for (int i = 0; i < NUM_FIELDS; i++)
      fields[(NUM_FIELDS-1-i)*FIELD_W +: FIELD_W] = FIELD_W'($signed(raw[i]));
    snap_in = {seq_inc, 5'b0, phase_tag, 1'b0, beta_quiet, 1'b0, sie_mask, fields};
  end

  // A capture while a frame is in flight (including its final handshake cycle) is only counted as a drop.
  always_comb begin
    rise = clk_en && !prev_en_q;
    cap = rise && dec_q == 8'(DECIM - 1);
    hs = state_q == SEND && m_ready;
    start = state_q == IDLE && cap;
    dec_d = cap ? 8'd0 : rise ? dec_q + 8'd1 : dec_q;
    state_d = start ? SEND : hs && idx_q == 6'(FRAME_LEN - 1) ? IDLE : state_q;
    idx_d = start ? 6'd0 : hs ? idx_q + 6'd1 : idx_q;
    csum_d = start ? 8'd0 : hs && idx_q >= 6'd2 && idx_q < 6'(FRAME_LEN - 1) ? csum_q ^ byte_w : csum_q;
    seq_d = start ? seq_inc : seq_q;
    snap_d = start ? snap_in : snap_q;
    drop_d = state_q == SEND && cap && drop_q != 16'hFFFF ? drop_q + 16'd1 : drop_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prev_en_q <= 1'b0;
      dec_q <= '0;
      idx_q <= '0;
      csum_q <= '0;
      seq_q <= '0;
      drop_q <= '0;
      snap_q <= '0;
    end else begin
      state_q <= state_d;
      prev_en_q <= clk_en;
      dec_q <= dec_d;
      idx_q <= idx_d;
      csum_q <= csum_d;
      seq_q <= seq_d;
      drop_q <= drop_d;
      snap_q <= snap_d;
    end
  end

  sr_frame_byte_mux u_mux (
    .snap(snap_q),
    .idx (idx_q),
    .csum(csum_q),
    .data(byte_w)
  );

  assign busy = state_q == SEND;
  assign m_valid = busy;
  assign m_data = busy ? byte_w : 8'h00;
  assign frame_seq = seq_q;
  assign drop_count = drop_q;
endmodule

// File: tb/tb_sr_gain_telemetry_framer.sv
// tb_sr_gain_telemetry_framer: scoreboard bench; expected frame bytes are queued at capture and popped on handshake.
module tb_sr_gain_telemetry_framer;
  localparam int W = 18;
  localparam int NH = 5;
  localparam int BW = NH * W;
  localparam int DECIM = 10;
  localparam int FLEN = 43;

  logic clk = 0, rst = 1, clk_en = 0, m_ready = 1, beta_quiet = 0;
  logic [2:0] phase_tag = 0;
  logic [BW-1:0] coh = 0, gain = 0;
  logic [W-1:0] beta = 0, dyn = 0;
  logic [NH-1:0] sie = 0;
  logic [7:0] m_data;
  logic m_valid, busy;
  logic [15:0] frame_seq, drop_count;

  int n_checks = 0, n_errors = 0, ecnt = 0;
  logic [7:0] q[$];
  logic [15:0] exp_seq = 0, exp_drop = 0;
  bit rnd = 0, stall = 0;
  logic [7:0] last_data = 0;

  sr_gain_telemetry_framer #(.WIDTH(W), .FRAC(14), .NUM_HARMONICS(NH), .DECIM(DECIM)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .phase_tag(phase_tag),
    .coherence_packed(coh), .gain_packed(gain), .beta_factor(beta), .dynamic_gain(dyn),
    .sie_mask(sie), .beta_quiet(beta_quiet), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .frame_seq(frame_seq), .drop_count(drop_count), .busy(busy)
  );

  always #4 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void push_frame(logic [15:0] s);
    logic [7:0] b [FLEN];
    int f [12];
    f[0] = $signed(beta);
    for (int h = 0; h < NH; h++) begin
      f[1+h] = $signed(coh[h*W +: W]);
      f[6+h] = $signed(gain[h*W +: W]);
    end
    f[11] = $signed(dyn);
    b[0] = 8'hA5;
    b[1] = 8'h5A;
    b[2] = s[15:8];
    b[3] = s[7:0];
    b[4] = {5'b0, phase_tag};
    b[5] = {1'b0, beta_quiet, 1'b0, sie};
    for (int i = 0; i < 12; i++) begin
      b[6+3*i] = f[i][23:16];
      b[7+3*i] = f[i][15:8];
      b[8+3*i] = f[i][7:0];
    end
    b[42] = 8'h00;
    for (int k = 2; k < 42; k++) b[42] ^= b[k];
    for (int k = 0; k < FLEN; k++) q.push_back(b[k]);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd) m_ready = 1'($urandom_range(0, 1));
  endtask

  // Raise clk_en for `hold` cycles; the model decides capture/drop from what is still owed on the link.
  task automatic en_edge(int hold);
    clk_en = 1;
    if (ecnt == DECIM - 1) begin
      ecnt = 0;
      if (q.size() != 0) exp_drop = exp_drop == 16'hFFFF ? exp_drop : exp_drop + 16'd1;
      else begin
        exp_seq++;
        push_frame(exp_seq);
      end
    end else ecnt++;
    repeat (hold) step();
    check("frame_seq", frame_seq, exp_seq);
    check("drop_count", drop_count, exp_drop);
    clk_en = 0;
    step();
  endtask

  task automatic capture();
    repeat (DECIM) en_edge(1);
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 3000) begin
      step();
      t++;
    end
    check("drain_left", q.size(), 0);
    rnd = 0;
    m_ready = 1;
    step();
    check("busy_after", busy, 0);
    check("valid_after", m_valid, 0);
  endtask

  task automatic rand_inputs();
    coh = BW'({$urandom(), $urandom(), $urandom()});
    gain = BW'({$urandom(), $urandom(), $urandom()});
    beta = W'($urandom());
    dyn = W'($urandom());
    sie = NH'($urandom());
    phase_tag = 3'($urandom());
    beta_quiet = 1'($urandom());
  endtask

  always @(negedge clk) begin
    if (rst) stall = 0;
    else begin
      if (stall && m_valid) check("stable", m_data, last_data);
      if (m_valid && m_ready) begin
        if (q.size() == 0) check("extra_byte_valid", m_valid, 0);
        else check($sformatf("byte%0d", FLEN - q.size()), m_data, q.pop_front());
      end
      stall = m_valid && !m_ready;
      last_data = m_data;
    end
  end

  initial begin
    int t;
    repeat (3) step();
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_busy", busy, 0);
    check("rst_seq", frame_seq, 0);
    check("rst_drop", drop_count, 0);
    rst = 0;
    step();
    // all-zero frame; one long clk_en level must count as a single edge
    repeat (8) en_edge(1);
    en_edge(5);
    check("no_early_frame", m_valid, 0);
    en_edge(1);
    drain();
    // signed fields and flag packing
    coh = '0;
    coh[0 +: W] = W'(-12288);
    gain = '0;
    gain[4*W +: W] = W'(16384);
    beta = W'(-1);
    dyn = W'(20000);
    beta_quiet = 1;
    sie = 5'b10101;
    phase_tag = 3;
    capture();
    drain();
    // random backpressure
    for (int n = 0; n < 3; n++) begin
      rand_inputs();
      rnd = 1;
      capture();
      drain();
    end
    // stalled at byte 0 across three more captures; snapshot must survive input changes
    rand_inputs();
    m_ready = 0;
    capture();
    check("pend_valid", m_valid, 1);
    check("pend_data", m_data, 8'hA5);
    rand_inputs();
    repeat (3) capture();
    check("pend_data2", m_data, 8'hA5);
    m_ready = 1;
    drain();
    // capture coinciding with the final handshake is dropped
    rand_inputs();
    capture();
    repeat (DECIM - 1) en_edge(1);
    t = 0;
    while (q.size() != 1 && t < 200) begin
      step();
      t++;
    end
    check("reach_last_byte", q.size(), 1);
    en_edge(1);
    check("last_busy", busy, 0);
    check("last_q", q.size(), 0);
    repeat (5) step();
    check("no_second_frame", m_valid, 0);
    // reset mid-frame at byte 20
    rand_inputs();
    capture();
    t = 0;
    while (q.size() != FLEN - 20 && t < 200) begin
      step();
      t++;
    end
    check("reach_byte20", q.size(), FLEN - 20);
    rst = 1;
    q.delete();
    ecnt = 0;
    exp_seq = 0;
    exp_drop = 0;
    step();
    check("mid_rst_valid", m_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_data", m_data, 0);
    check("mid_rst_seq", frame_seq, 0);
    rst = 0;
    step();
    rand_inputs();
    capture();
    drain();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
